// File: rtl/bist_pkg.sv
// Shared types, default feedback masks and the shift/feedback step used by the
// BIST pattern generator and signature register.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    // Widest register lfsr_next can step; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    // x^35 + x^33 + 1 and x^49 + x^40 + 1 (maximal length).
    localparam logic [34:0] DEF_LFSR_TAPS = 35'h5_0000_0000;
    localparam logic [48:0] DEF_MISR_TAPS = 49'h1_0080_0000_0000;

    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps);
        return {state[MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/bist_engine_if.sv
// Bundle of the BIST control/status and CUT-side signals seen by bist_engine.
interface bist_engine_if #(
    parameter int PI_W = 35,
    parameter int PO_W = 49
);
    logic            bistmode;
    logic [PI_W-1:0] sys_pi;
    logic [PO_W-1:0] cut_po;
    logic [PI_W-1:0] cut_pi;
    logic            bistdone;
    logic            bistpass;
    logic [PO_W-1:0] signature;

    modport master (
        output bistmode, sys_pi, cut_po,
        input  cut_pi, bistdone, bistpass, signature
    );

    modport slave (
        input  bistmode, sys_pi, cut_po,
        output cut_pi, bistdone, bistpass, signature
    );
endinterface

// File: rtl/bist_lfsr.sv
// Left-shifting LFSR with parallel XOR input: par_in=0 generates patterns,
// par_in=CUT response makes it a MISR.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int           W    = 4,
    parameter logic [W-1:0] TAPS = '0,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] q
);

    logic [W-1:0] shifted;

    assign shifted = W'(lfsr_next(MAX_W'(q), MAX_W'(TAPS)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= INIT;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= shifted ^ par_in;
        end
    end

endmodule

// File: rtl/bist_engine.sv
// BIST controller: LFSR drives the CUT, MISR compacts its response, and the
// final signature is checked against GOLDEN_SIG; otherwise sys_pi passes through.
module bist_engine
    import bist_pkg::*;
#(
    parameter int              PI_W         = 35,
    parameter int              PO_W         = 49,
    parameter int              NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0] LFSR_TAPS    = PI_W'(DEF_LFSR_TAPS),
    parameter logic [PO_W-1:0] MISR_TAPS    = PO_W'(DEF_MISR_TAPS),
    parameter logic [PI_W-1:0] SEED         = PI_W'(1),
    parameter logic [PO_W-1:0] GOLDEN_SIG   = '0
) (
    input logic          clk,
    input logic          rst,
    bist_engine_if.slave bus
);

    localparam int              CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [PI_W-1:0] SEED_EFF = (SEED == '0) ? PI_W'(1) : SEED;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_PATTERNS - 1);

    bist_state_t     state, state_next;
    logic [CNT_W-1:0] count;
    logic            pass_r;
    logic            done_q;
    logic            pass_q;
    logic            in_idle;
    logic            in_run;
    logic [PI_W-1:0] lfsr_q;
    logic [PO_W-1:0] misr_q;

    assign in_idle = (state == ST_IDLE);
    assign in_run  = (state == ST_RUN);

    bist_lfsr #(.W(PI_W), .TAPS(LFSR_TAPS), .INIT(SEED_EFF)) u_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (in_run),
        .load     (in_idle),
        .load_val (SEED_EFF),
        .par_in   ('0),
        .q        (lfsr_q)
    );

    bist_lfsr #(.W(PO_W), .TAPS(MISR_TAPS), .INIT('0)) u_misr (
        .clk      (clk),
        .rst      (rst),
        .en       (in_run),
        .load     (in_idle),
        .load_val ('0),
        .par_in   (bus.cut_po),
        .q        (misr_q)
    );

    // Dropping bistmode anywhere outside IDLE returns there; DONE only exits that way.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bus.bistmode) state_next = ST_RUN;
            ST_RUN:     if (!bus.bistmode) state_next = ST_IDLE;
                        else if (count == LAST) state_next = ST_COMPARE;
            ST_COMPARE: state_next = bus.bistmode ? ST_DONE : ST_IDLE;
            ST_DONE:    if (!bus.bistmode) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            pass_r <= 1'b0;
        end else begin
            state <= state_next;
            if (in_idle) begin
                count <= '0;
            end else if (in_run) begin
                count <= count + 1'b1;
            end
            if (state == ST_COMPARE) begin
                pass_r <= (misr_q == GOLDEN_SIG);
            end
        end
    end

    // Status flags trail DONE entry by one cycle and clear on the exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (state == ST_DONE && bus.bistmode) begin
            done_q <= 1'b1;
            pass_q <= pass_r;
        end else begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end
    end

    assign bus.cut_pi    = in_run ? lfsr_q : bus.sys_pi;
    assign bus.bistdone  = done_q;
    assign bus.bistpass  = pass_q;
    assign bus.signature = misr_q;

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: 4-bit LFSR/MISR around an identity CUT,
// with a reference model feeding a scoreboard of expected patterns/signatures.
module tb_bist_engine;

    localparam int         W      = 4;
    localparam int         N      = 3;
    localparam logic [3:0] TAPS   = 4'b1100;
    localparam logic [3:0] SEED   = 4'b0001;
    localparam logic [3:0] GOLDEN = 4'b0100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] po_mask = 4'hF;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_pi_q[$];
    logic [3:0] exp_sig_q[$];

    always #5 clk = ~clk;

    bist_engine_if #(.PI_W(W), .PO_W(W)) bus ();

    // Identity CUT; po_mask models stuck-at-0 faults on the outputs.
    assign bus.cut_po = bus.cut_pi & po_mask;

    bist_engine #(
        .PI_W(W), .PO_W(W), .NUM_PATTERNS(N),
        .LFSR_TAPS(TAPS), .MISR_TAPS(TAPS), .SEED(SEED), .GOLDEN_SIG(GOLDEN)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [3:0] model_step(input logic [3:0] s, input logic [3:0] t);
        return {s[2:0], ^(s & t)};
    endfunction

    // Starts a run from IDLE, checks every pattern/signature, then the done timing.
    task automatic run_bist(input logic [3:0] mask, input logic exp_pass, input logic [3:0] exp_final);
        logic [3:0] lf;
        logic [3:0] mi;
        int waited;
        lf = SEED;
        mi = 4'b0000;
        po_mask = mask;
        for (int k = 0; k < N; k++) begin
            exp_pi_q.push_back(lf);
            mi = model_step(mi, TAPS) ^ (lf & mask);
            exp_sig_q.push_back(mi);
            lf = model_step(lf, TAPS);
        end
        @(negedge clk);
        bus.bistmode = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            logic [3:0] e;
            e = exp_pi_q.pop_front();
            checks++;
            if (bus.cut_pi !== e) begin
                errors++;
                $display("[TB] FAIL pattern%0d: cut_pi=%b expected %b", k + 1, bus.cut_pi, e);
            end
            @(negedge clk);
            e = exp_sig_q.pop_front();
            checks++;
            if (bus.signature !== e) begin
                errors++;
                $display("[TB] FAIL misr%0d: signature=%b expected %b", k + 1, bus.signature, e);
            end
        end
        waited = N;
        while (bus.bistdone !== 1'b1 && waited < N + 10) begin
            checks++;
            if (bus.bistpass !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pass_before_done: bistpass=%b expected 0", bus.bistpass);
            end
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != N + 2) begin
            errors++;
            $display("[TB] FAIL done_latency: %0d cycles expected %0d", waited, N + 2);
        end
        checks++;
        if (bus.bistpass !== exp_pass) begin
            errors++;
            $display("[TB] FAIL bistpass: got %b expected %b", bus.bistpass, exp_pass);
        end
        checks++;
        if (bus.signature !== exp_final) begin
            errors++;
            $display("[TB] FAIL final_sig: got %b expected %b", bus.signature, exp_final);
        end
        po_mask = 4'hF;
    endtask

    task automatic end_run();
        bus.bistmode = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bistdone !== 1'b0 || bus.bistpass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL end_run: done=%b pass=%b expected 0 0", bus.bistdone, bus.bistpass);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (bus.bistdone !== 1'b0 || bus.bistpass !== 1'b0 || bus.signature !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: done=%b pass=%b sig=%b expected 0 0 0000",
                     bus.bistdone, bus.bistpass, bus.signature);
        end
        checks++;
        if (bus.cut_pi !== bus.sys_pi) begin
            errors++;
            $display("[TB] FAIL reset_mux: cut_pi=%b expected %b", bus.cut_pi, bus.sys_pi);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_golden_pass();
        run_bist(4'hF, 1'b1, GOLDEN);
        end_run();
    endtask

    task automatic test_fault_detect();
        run_bist(4'b1011, 1'b0, 4'b0000);
        end_run();
    endtask

    task automatic test_system_mode();
        bus.bistmode = 1'b0;
        bus.sys_pi = 4'b1010;
        #1;
        checks++;
        if (bus.cut_pi !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL sys_passthru: cut_pi=%b expected 1010", bus.cut_pi);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.bistdone !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sys_done: bistdone=%b expected 0", bus.bistdone);
            end
        end
    endtask

    task automatic test_abort();
        bus.sys_pi = 4'b1111;
        @(negedge clk);
        bus.bistmode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.cut_pi !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL abort_run: cut_pi=%b expected 0010", bus.cut_pi);
        end
        bus.bistmode = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cut_pi !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL abort_idle: cut_pi=%b expected 1111", bus.cut_pi);
        end
        @(negedge clk);
        checks++;
        if (bus.signature !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_misr: signature=%b expected 0000", bus.signature);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.bistdone !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_done: bistdone=%b expected 0", bus.bistdone);
            end
        end
        run_bist(4'hF, 1'b1, GOLDEN);
        end_run();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.bistmode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.bistdone !== 1'b0 || bus.bistpass !== 1'b0 || bus.signature !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_outputs: done=%b pass=%b sig=%b expected 0 0 0000",
                     bus.bistdone, bus.bistpass, bus.signature);
        end
        checks++;
        if (bus.cut_pi !== bus.sys_pi) begin
            errors++;
            $display("[TB] FAIL async_mux: cut_pi=%b expected %b", bus.cut_pi, bus.sys_pi);
        end
        bus.bistmode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_bist(4'hF, 1'b1, GOLDEN);
        end_run();
    endtask

    task automatic test_hold_done();
        run_bist(4'hF, 1'b1, GOLDEN);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.bistdone !== 1'b1 || bus.bistpass !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_flags: done=%b pass=%b expected 1 1", bus.bistdone, bus.bistpass);
            end
            checks++;
            if (bus.signature !== GOLDEN || bus.cut_pi !== bus.sys_pi) begin
                errors++;
                $display("[TB] FAIL hold_rerun: sig=%b cut_pi=%b expected %b %b",
                         bus.signature, bus.cut_pi, GOLDEN, bus.sys_pi);
            end
        end
        end_run();
        run_bist(4'hF, 1'b1, GOLDEN);
        end_run();
    endtask

    initial begin
        bus.bistmode = 1'b0;
        bus.sys_pi = 4'b0110;
        test_reset();
        test_golden_pass();
        test_fault_detect();
        test_system_mode();
        test_abort();
        test_async_reset();
        test_hold_done();
        checks++;
        if (exp_pi_q.size() != 0 || exp_sig_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left", exp_pi_q.size(), exp_sig_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bist_engine.md
# bist_engine

Parametrised built-in self-test engine that wraps a combinational or pipelined circuit-under-test (CUT) inside `chip`. In BIST mode it drives the CUT inputs from an LFSR pattern generator, compacts the CUT outputs in a MISR, and compares the final signature against a golden value. In system mode it passes primary inputs straight through. It generalises the fixed 35-in/49-out BIST of the current chip to arbitrary widths, pattern counts and polynomials. It also adds abort, restart and signature readout.

## Interface
- `PI_W`, 35, CUT input width (≥2)
- `PO_W`, 49, CUT output width (≥2)
- `NUM_PATTERNS`, 2000, patterns applied per run (≥1)
- `LFSR_TAPS`, PI_W-bit feedback mask, default from `bist_pkg`
- `MISR_TAPS`, PO_W-bit feedback mask, default from `bist_pkg`
- `SEED`, PI_W'd1, LFSR initial state
- `GOLDEN_SIG`, PO_W'd0, expected final MISR value
- `clk`, in, 1, clock; all state on rising edge
- `rst`, in, 1, asynchronous, active-low reset
- `bistmode`, in, 1, 1 requests/holds a BIST run; 0 = system mode
- `sys_pi`, in, PI_W, functional primary inputs
- `cut_po`, in, PO_W, CUT outputs
- `cut_pi`, out, PI_W, CUT inputs: LFSR state in RUN, else `sys_pi` (combinational mux)
- `bistdone`, out, 1, run complete, held in DONE
- `bistpass`, out, 1, signature matched, valid while `bistdone`=1
- `signature`, out, PO_W, current MISR contents (readout/debug)

## Operation
- States: IDLE, RUN, COMPARE, DONE (`bist_state_t`).
- IDLE: LFSR=SEED (SEED==0 replaced by 1), MISR=0, count=0. `bistmode`=1 at an edge → RUN.
- RUN: `cut_pi`=LFSR. On each edge:
  - LFSR ← {lfsr[PI_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - MISR ← {misr[PO_W-2:0], ^(misr & MISR_TAPS)} ^ `cut_po`.
  - count++.
  - When the edge captures pattern number NUM_PATTERNS → COMPARE.
- COMPARE: registers pass ← (MISR == GOLDEN_SIG) and moves to DONE. MISR is frozen.
- DONE: `bistdone`=1, `bistpass`=registered result, MISR frozen. Stays until `bistmode`=0 → IDLE (flags cleared on that edge).
- Abort: `bistmode`=0 in RUN or COMPARE → IDLE at next edge. `bistdone` never asserts. MISR/LFSR are reinitialised in IDLE.
- Restart: `bistmode` held 1 in DONE does not rerun. A fresh run needs a 0 for ≥1 cycle, then 1.
- Counter width is $clog2(NUM_PATTERNS+1). No wrap is possible.
- `rst`=0 at any time: immediately state=IDLE, `bistdone`=0, `bistpass`=0, `signature`=0, LFSR=SEED, count=0. `cut_pi` follows `sys_pi`.

## Timing
- Edge E0 samples `bistmode`=1 in IDLE. Pattern 1 (SEED) is on `cut_pi` during cycle E0→E1 and is compacted at E1.
- Pattern k is compacted at edge Ek. RUN→COMPARE occurs at E_NUM_PATTERNS.
- `bistdone` rises at E_NUM_PATTERNS+2, i.e. NUM_PATTERNS+2 cycles after the start edge.
- The CUT must settle `cut_po` within one cycle of `cut_pi`. Registered CUTs are outside scope.
- `bistpass` and `bistdone` change on the same edge. `bistpass` is 0 whenever `bistdone` is 0.

## Structure
- `bist_pkg`: `bist_state_t` enum; default tap constants for the 35-bit LFSR and 49-bit MISR; function `lfsr_next(state, taps)`.
- Sub-module `bist_lfsr` (parameters W, TAPS; ports en, load, load_val, par_in, q):
  - par_in=0 gives the generator; par_in=`cut_po` gives the MISR.
  - Instantiated twice.
- `bist_engine` holds the FSM, counter, compare register and output mux.

## Test plan
All scenarios use PI_W=PO_W=4, LFSR_TAPS=MISR_TAPS=4'b1100, SEED=4'b0001, NUM_PATTERNS=3, with an identity CUT (`cut_po`=`cut_pi`).
- **Golden pass:** GOLDEN_SIG=4'b0100, `bistmode`=1 after reset.
  - `cut_pi` sequence is 0001, 0010, 0100.
  - MISR sequence is 0001, 0000, 0100.
  - `bistdone`=1 and `bistpass`=1 exactly 5 cycles after the start edge.
- **Fault detect:** force `cut_po[2]`=0.
  - Final signature is 4'b0000.
  - `bistdone`=1 and `bistpass`=0.
- **System mode:** `bistmode`=0, `sys_pi`=4'b1010.
  - `cut_pi`=4'b1010 in the same cycle.
  - `bistdone`=0 indefinitely.
- **Abort:** deassert `bistmode` after 2 RUN cycles.
  - IDLE at the next edge and `bistdone` never rises.
  - Re-asserting `bistmode` gives pass in 5 cycles.
- **Async reset mid-RUN:** `rst`=0 between edges.
  - Outputs are 0 and `signature`=0 immediately.
  - After release, a new run starts from SEED 0001.
- **Hold in DONE:** keep `bistmode`=1 for 10 extra cycles.
  - `bistdone` and `bistpass` remain stable with no rerun.
  - Drop then raise `bistmode`: the run repeats with the identical result.
